spi_slave_port: RTL and testbench
=================================

// Module: spi_slave_port
// PURPOSE
//  Parametrised SPI slave for the filter-configuration path. Oversamples SCK/CS/MOSI in the clk
//  domain, supports all four SPI modes and a configurable word width, returns a readback word on
//  MISO, and flags malformed frames. Delivers one word per CS frame to the config register bank.
// PARAMETERS
//  DATA_W      16  bits per frame; rx/tx word width (>=2)
//  SYNC_STAGES 2   synchroniser flops on spi_clk, spi_cs_n, spi_mosi (>=2)
//  CPOL        0   SCK idle level; leading edge = rising if 0, falling if 1
//  CPHA        0   0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//  MSB_FIRST   1   1: MSB first on both MOSI and MISO; 0: LSB first
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  spi_clk    in   1       SPI SCK (async to clk)
//  spi_cs_n   in   1       chip select, active-low (async)
//  spi_mosi   in   1       master-out serial data (async)
//  spi_miso   out  1       slave-out serial data
//  tx_data    in   DATA_W  readback word, captured at frame start
//  rx_data    out  DATA_W  last correctly framed received word
//  rx_valid   out  1       1-clk pulse: rx_data updated
//  frame_err  out  1       1-clk pulse: frame ended with bit count != DATA_W
//  busy       out  1       high while FSM in ACTIVE
// BEHAVIOUR
//  Reset: rx_data=0, rx_valid=0, frame_err=0, busy=0, spi_miso=0, shift regs=0, bit_cnt=0, FSM=IDLE.
//   Reset is honoured mid-frame; the partial frame is discarded, no rx_valid/frame_err after release.
//  Sync: every input passes SYNC_STAGES flops; edges detected by comparing last two synced samples.
//   Inputs with SCK high/low phases each >= SYNC_STAGES+2 clk periods are supported.
//  FSM IDLE:   synced cs_n falling edge -> tx_shift<=tx_data, rx_shift<=0, bit_cnt<=0, first_edge<=1, ACTIVE.
//   SCK edges in IDLE are ignored.
//  FSM ACTIVE: busy=1.
//   Sample edge: rx_shift shifts in synced MOSI (toward MSB if MSB_FIRST, else toward LSB);
//    bit_cnt increments, saturating at DATA_W+1 (overrun marker).
//   Shift edge: tx_shift advances one bit. With CPHA=1, the first leading edge of a frame does not
//    advance (first_edge cleared instead) so bit 0 of the frame is driven for the first sample.
//   spi_miso = tx_shift[DATA_W-1] (MSB_FIRST) or tx_shift[0], valid from the clk after CS-fall
//    detection. Beyond DATA_W shifts, MISO drives 0.
//   Synced cs_n rising edge -> IDLE; next clk:
//    bit_cnt==DATA_W: rx_data<=rx_shift, rx_valid=1 for one clk.
//    otherwise (short or overrun): frame_err=1 for one clk, rx_data unchanged.
//   A SCK sample edge and CS rise in the same clk: the CS rise wins; the bit is not counted.
//  Latency: rx_valid rises SYNC_STAGES+2 clk after the spi_cs_n pin rises.
//  Outside ACTIVE, spi_miso=0. Back-to-back frames need cs_n high >= SYNC_STAGES+2 clk.
//  bit_cnt width = $clog2(DATA_W+2).
// TESTING
//  1 Mode 0, DATA_W=16: send 0xA5C3 MSB first, tx_data=0x1234 -> rx_data=0xA5C3, one rx_valid pulse, MISO bits = 0x1234.
//  2 All four CPOL/CPHA combos, word 0x8001 -> rx_data=0x8001 each time; MISO returns tx_data=0x7FFE intact.
//  3 Short frame (15 SCK cycles) then CS high -> frame_err pulse, rx_valid=0, rx_data keeps previous 0xA5C3.
//  4 Overrun (17 SCK cycles) -> frame_err pulse; next correct frame 0x0F0F -> rx_valid, rx_data=0x0F0F.
//  5 Assert rst_n=0 after 8 bits, release, send 0x00FF -> no stray pulses; rx_data=0x00FF after the frame.
//  6 DATA_W=24, MSB_FIRST=0: send 0x123456 LSB first -> rx_data=0x123456; SCK edges with CS high ignored.

Source files
------------

// File: rtl/spi_slave_port.sv
// spi_slave_port: oversampling SPI slave for the filter-configuration path.
// SCK, CS_n and MOSI are synchronised into clk. Edges are found by comparing the
// last two synchronised samples. One DATA_W-bit word is received per CS frame, and a
// readback word is shifted out on MISO. A frame that ends with the wrong number of
// sample edges raises frame_err instead of rx_valid.
module spi_slave_port #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_W);
  // Past a complete word, the counter sticks at this value so that an overrun cannot wrap back to DATA_W.
  localparam logic [CW-1:0] OVR_CNT  = CW'(DATA_W + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sck_pipe, cs_pipe, mosi_pipe;
  logic                   sck_prev, cs_prev;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge, cs_fall, cs_rise;
  logic [DATA_W-1:0]      rx_shift, tx_shift;
  logic [CW-1:0]          bit_cnt;
  logic                   first_edge;
  logic                   end_pending;

  // Synchronisers plus one extra sample of SCK/CS_n for edge detection.
  // They reset to 0, so a CS_n that is low when reset is released never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_pipe  <= '0;
      cs_pipe   <= '0;
      mosi_pipe <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_clk};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], spi_cs_n};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_pipe[SYNC_STAGES-1];
      cs_prev   <= cs_pipe[SYNC_STAGES-1];
    end
  end

  // Classify the synchronised SCK edges as sample or shift edges for the selected SPI mode.
  always_comb begin
    sck_s       = sck_pipe[SYNC_STAGES-1];
    cs_s        = cs_pipe[SYNC_STAGES-1];
    mosi_s      = mosi_pipe[SYNC_STAGES-1];
    sck_rise    = sck_s & ~sck_prev;
    sck_fall    = ~sck_s & sck_prev;
    lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
    trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
    sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    cs_fall     = ~cs_s & cs_prev;
    cs_rise     = cs_s & ~cs_prev;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next state: a frame is bracketed by synchronised CS_n edges.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame datapath: load at frame start, shift while the frame is active,
  // and report the frame one clk after CS_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift    <= '0;
      tx_shift    <= '0;
      bit_cnt     <= '0;
      first_edge  <= 1'b0;
      end_pending <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      end_pending <= 1'b0;
      if (end_pending) begin
        if (bit_cnt == FULL_CNT) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            tx_shift   <= tx_data;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            first_edge <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // A sample edge that arrives in the same clk as the CS_n rise is dropped.
            end_pending <= 1'b1;
          end else begin
            if (sample_edge) begin
              if (MSB_FIRST != 0) rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
              else                rx_shift <= {mosi_s, rx_shift[DATA_W-1:1]};
              if (bit_cnt != OVR_CNT) bit_cnt <= bit_cnt + 1'b1;
            end
            if (shift_edge) begin
              if ((CPHA != 0) && first_edge) begin
                // With CPHA=1, bit 0 must still be on MISO when the first sample edge arrives.
                first_edge <= 1'b0;
              end else if (MSB_FIRST != 0) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              end else begin
                tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Drive MISO only inside a frame. Zero fill makes MISO read 0 after DATA_W shifts.
  always_comb begin
    busy     = (state_reg == ACTIVE);
    spi_miso = 1'b0;
    if (state_reg == ACTIVE)
      spi_miso = (MSB_FIRST != 0) ? tx_shift[DATA_W-1] : tx_shift[0];
  end

endmodule

// File: tb/tb_spi_slave_port.sv
// Testbench for spi_slave_port. Four 16-bit MSB-first instances cover the four CPOL/CPHA
// modes, and one 24-bit LSB-first instance covers the other word width and bit order.
// All instances share SCK and MOSI, and each one has its own CS_n.
// An unselected instance must ignore the traffic that is meant for another instance.
module tb_spi_slave_port;
  localparam int S = 2;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck_raw, mosi;
  logic [4:0]  cs_n;
  logic [15:0] tx16 [4];
  logic [15:0] rx16 [4];
  logic        miso16 [4];
  logic        rv16 [4];
  logic        fe16 [4];
  logic        busy16 [4];
  logic [23:0] tx24, rx24;
  logic        miso24, rv24, fe24, busy24;

  logic [2:0]  sel;
  logic        miso_s, rv_s, fe_s, busy_s;
  logic [23:0] rx_s;

  int vectors = 0;
  int miscompares = 0;
  int rv_cnt [5] = '{default: 0};
  int fe_cnt [5] = '{default: 0};
  int exp_rv [5] = '{default: 0};
  logic [23:0] last_rx [5];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mode
      localparam bit POL = (gi / 2) != 0;
      spi_slave_port #(.DATA_W(16), .SYNC_STAGES(S), .CPOL(gi / 2), .CPHA(gi % 2), .MSB_FIRST(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(sck_raw ^ POL), .spi_cs_n(cs_n[gi]), .spi_mosi(mosi),
        .spi_miso(miso16[gi]), .tx_data(tx16[gi]), .rx_data(rx16[gi]), .rx_valid(rv16[gi]),
        .frame_err(fe16[gi]), .busy(busy16[gi]));
    end
  endgenerate

  spi_slave_port #(.DATA_W(24), .SYNC_STAGES(S), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u_w24 (
    .clk(clk), .rst_n(rst_n), .spi_clk(sck_raw), .spi_cs_n(cs_n[4]), .spi_mosi(mosi),
    .spi_miso(miso24), .tx_data(tx24), .rx_data(rx24), .rx_valid(rv24),
    .frame_err(fe24), .busy(busy24));

  always_comb begin
    miso_s = miso24; rv_s = rv24; fe_s = fe24; busy_s = busy24; rx_s = rx24;
    if (sel < 3'd4) begin
      miso_s = miso16[sel[1:0]];
      rv_s   = rv16[sel[1:0]];
      fe_s   = fe16[sel[1:0]];
      busy_s = busy16[sel[1:0]];
      rx_s   = {8'h00, rx16[sel[1:0]]};
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rv_cnt[i] <= rv_cnt[i] + (rv16[i] ? 1 : 0);
      fe_cnt[i] <= fe_cnt[i] + (fe16[i] ? 1 : 0);
    end
    rv_cnt[4] <= rv_cnt[4] + (rv24 ? 1 : 0);
    fe_cnt[4] <= fe_cnt[4] + (fe24 ? 1 : 0);
  end

  function automatic int wid(input int i);
    return (i < 4) ? 16 : 24;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tx(input int i, input logic [23:0] v);
    if (i < 4) tx16[i] = v[15:0];
    else       tx24 = v;
  endtask

  task automatic start_frame(input int i);
    sel = 3'(i);
    @(negedge clk);
    cs_n[i] = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  // The master drives the word and collects the MISO bits into the bit positions of the word.
  task automatic send_bits(input int i, input logic [23:0] word, input int nbits,
                           output logic [23:0] got, output int extra_ones);
    int  w;
    int  pos;
    bit  cpha, msb;
    logic d;
    w = wid(i);
    cpha = (i < 4) && (i % 2 == 1);
    msb = (i < 4);
    got = '0;
    extra_ones = 0;
    for (int b = 0; b < nbits; b++) begin
      if (b < w) d = msb ? word[w-1-b] : word[b];
      else       d = 1'($urandom_range(0, 1));
      pos = msb ? (w - 1 - b) : b;
      if (!cpha) begin
        mosi = d;
        repeat (H) @(negedge clk);
        if (b < w) got[pos] = miso_s; else extra_ones += int'(miso_s);
        sck_raw = 1'b1;
        repeat (H) @(negedge clk);
        sck_raw = 1'b0;
      end else begin
        sck_raw = 1'b1;
        mosi = d;
        repeat (H) @(negedge clk);
        if (b < w) got[pos] = miso_s; else extra_ones += int'(miso_s);
        sck_raw = 1'b0;
        repeat (H) @(negedge clk);
      end
    end
    repeat (H) @(negedge clk);
  endtask

  task automatic end_frame(input int i, output int lat, output int nv, output int ne);
    cs_n[i] = 1'b1;
    lat = -1; nv = 0; ne = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rv_s || fe_s) begin
        if (lat < 0) lat = k;
        nv += int'(rv_s);
        ne += int'(fe_s);
      end
    end
  endtask

  // Full frame with the model check. The expected results follow only from the bit count and the words.
  task automatic run_frame(input int i, input logic [23:0] tx, input logic [23:0] word, input int nbits);
    logic [23:0] got, mask;
    int extra, lat, nv, ne, w;
    w = wid(i);
    mask = (w == 24) ? 24'hFFFFFF : 24'h00FFFF;
    set_tx(i, tx & mask);
    start_frame(i);
    check($sformatf("busy_in_frame[%0d]", i), 32'(busy_s), 32'd1);
    set_tx(i, 24'($urandom) & mask);
    send_bits(i, word & mask, nbits, got, extra);
    end_frame(i, lat, nv, ne);
    if (nbits == w) begin
      last_rx[i] = word & mask;
      exp_rv[i]++;
    end
    check($sformatf("pulse_latency[%0d]", i), 32'(lat), 32'(S + 2));
    check($sformatf("rx_valid_pulses[%0d]", i), 32'(nv), (nbits == w) ? 32'd1 : 32'd0);
    check($sformatf("frame_err_pulses[%0d]", i), 32'(ne), (nbits == w) ? 32'd0 : 32'd1);
    check($sformatf("rx_data[%0d]", i), 32'(rx_s), 32'(last_rx[i]));
    check($sformatf("busy_after[%0d]", i), 32'(busy_s), 32'd0);
    if (nbits >= w) check($sformatf("miso_word[%0d]", i), 32'(got), 32'(tx & mask));
    if (nbits > w)  check($sformatf("miso_overrun_zero[%0d]", i), 32'(extra), 32'd0);
    $display("frame inst=%0d nbits=%0d word=%0h tx=%0h rx=%0h miso=%0h valid=%0d err=%0d lat=%0d",
             i, nbits, word & mask, tx & mask, rx_s, got, nv, ne, lat);
  endtask

  initial begin
    logic [23:0] got, word;
    int extra, rv0, fe0, inst, nb, w;
    rst_n = 1'b0; sck_raw = 1'b0; mosi = 1'b0; cs_n = '1; sel = 3'd0; tx24 = '0;
    for (int i = 0; i < 4; i++) tx16[i] = '0;
    for (int i = 0; i < 5; i++) last_rx[i] = '0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sel = 3'(i);
      #1;
      check($sformatf("reset_rx_data[%0d]", i), 32'(rx_s), 32'd0);
      check($sformatf("reset_flags[%0d]", i), {28'd0, rv_s, fe_s, busy_s, miso_s}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Mode 0 basic frame, then a short frame, then an overrun followed by a good frame.
    run_frame(0, 24'h1234, 24'hA5C3, 16);
    run_frame(0, 24'h5A5A, 24'h7777, 15);
    run_frame(0, 24'h3C3C, 24'h1111, 17);
    run_frame(0, 24'h0001, 24'h0F0F, 16);

    // All four CPOL/CPHA modes.
    for (int m = 0; m < 4; m++) run_frame(m, 24'h7FFE, 24'h8001, 16);

    // Reset in the middle of a frame, with CS_n still low at release.
    rv0 = rv_cnt[0]; fe0 = fe_cnt[0];
    set_tx(0, 24'hBEEF);
    start_frame(0);
    send_bits(0, 24'hFFFF, 8, got, extra);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) last_rx[i] = '0;
    check("reset_mid_busy", 32'(busy_s), 32'd0);
    check("reset_mid_rx_data", 32'(rx_s), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    cs_n[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("reset_no_valid", 32'(rv_cnt[0] - rv0), 32'd0);
    check("reset_no_err", 32'(fe_cnt[0] - fe0), 32'd0);
    run_frame(0, 24'h4321, 24'h00FF, 16);

    // 24-bit LSB-first instance.
    run_frame(4, 24'hC0FFEE, 24'h123456, 24);

    // Random frames over all instances, with an occasional wrong bit count.
    for (int r = 0; r < 20; r++) begin
      inst = int'($urandom_range(0, 4));
      w = wid(inst);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, w + 2)) : w;
      word = 24'($urandom);
      run_frame(inst, 24'($urandom), word, nb);
    end

    // Each instance must have pulsed only for its own complete frames.
    for (int i = 0; i < 5; i++)
      check($sformatf("total_valid[%0d]", i), 32'(rv_cnt[i]), 32'(exp_rv[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
